// File: rtl/stream_arb_mux_pkg.sv
// Shared definitions for the stream arbiter/mux: select-width helper and arbitration mode encodings.
package stream_arb_mux_pkg;

  localparam int unsigned RR_MODE_FIXED = 0;
  localparam int unsigned RR_MODE_ROUND = 1;

  // Index width for n channels, never narrower than one bit
  function automatic int unsigned sel_w(input int unsigned n);
    int unsigned w;
    w = 1;
    if (n > 2) w = $clog2(n);
    return w;
  endfunction

endpackage

// File: rtl/stream_arb_mux_if.sv
// Handshake bundle between N_IN upstream channels, the arbiter/mux and one downstream sink.
interface stream_arb_mux_if
  import stream_arb_mux_pkg::*;
#(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned N_IN  = 4
);

  localparam int unsigned SEL_W = sel_w(N_IN);

  logic [N_IN-1:0]       in_valid;
  logic [N_IN*WIDTH-1:0] in_data;
  logic [N_IN-1:0]       in_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_sel;
  logic                  out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/stream_arb_mux_rr_arbiter.sv
// Request arbiter: round-robin from a rotating pointer, or fixed lowest-index priority.
module rr_arbiter
  import stream_arb_mux_pkg::*;
#(
  parameter int unsigned N_IN    = 4,
  parameter int unsigned RR_MODE = RR_MODE_ROUND,
  localparam int unsigned SEL_W  = sel_w(N_IN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  req_i,
  input  logic             advance_i,
  output logic [N_IN-1:0]  grant_c_o,
  output logic [SEL_W-1:0] index_c_o
);

  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] ptr_d;
  logic             found_c;
  int unsigned      start_c;

  // Scan from the start position with wrap; first requester wins
  always_comb begin
    grant_c_o = '0;
    index_c_o = '0;
    found_c   = 1'b0;
    start_c   = (RR_MODE == RR_MODE_ROUND) ? 32'(ptr_q) : 32'd0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (!found_c && req_i[SEL_W'((start_c + k) % N_IN)]) begin
        found_c = 1'b1;
        grant_c_o[SEL_W'((start_c + k) % N_IN)] = 1'b1;
        index_c_o = SEL_W'((start_c + k) % N_IN);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (index_c_o == SEL_W'(N_IN - 1)) ? '0 : index_c_o + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/stream_arb_mux.sv
// N-to-1 stream arbiter/mux with a single registered output stage.
module stream_arb_mux
  import stream_arb_mux_pkg::*;
#(
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned N_IN    = 4,
  parameter int unsigned RR_MODE = RR_MODE_ROUND
) (
  input logic             clk,
  input logic             rst_n,
  stream_arb_mux_if.slave bus
);

  localparam int unsigned SEL_W = sel_w(N_IN);

  logic [N_IN-1:0]  grant_c;
  logic [SEL_W-1:0] index_c;
  logic [N_IN-1:0]  in_ready_c;
  logic             load_c;
  logic [WIDTH-1:0] sel_data_c;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_sel_q,   out_sel_d;

  // Output slot is free when empty or being drained this cycle; never during reset
  assign load_c     = rst_n & (~out_valid_q | bus.out_ready);
  assign in_ready_c = grant_c & {N_IN{load_c}};

  rr_arbiter #(
    .N_IN    (N_IN),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (bus.in_valid),
    .advance_i (|in_ready_c),
    .grant_c_o (grant_c),
    .index_c_o (index_c)
  );

  always_comb begin
    sel_data_c = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (grant_c[i]) sel_data_c = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  // Data and index hold their last value when the slot drains empty
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (load_c) begin
      out_valid_d = |grant_c;
      if (|grant_c) begin
        out_data_d = sel_data_c;
        out_sel_d  = index_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: doc/stream_arb_mux.md
STREAM_ARB_MUX -- requirements
Module: stream_arb_mux

Interface
REQ-001 Parameter WIDTH, default 5: data width per channel in bits, legal 1..64.
REQ-002 Parameter N_IN, default 4: number of input channels, legal 2..16.
REQ-003 Parameter RR_MODE, default 1: 1 selects round-robin arbitration, 0 selects fixed priority (lowest index wins).
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 Port in_valid, input, N_IN: per-channel request, bit i belongs to channel i.
REQ-007 Port in_data, input, N_IN*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 Port in_ready, output, N_IN: per-channel accept, one-hot or zero.
REQ-009 Port out_valid, output, 1: output register holds a valid word.
REQ-010 Port out_data, output, WIDTH: registered selected word.
REQ-011 Port out_sel, output, max(1,clog2(N_IN)): index of the channel that produced out_data.
REQ-012 Port out_ready, input, 1: downstream accept.

Function
REQ-013 Transfer on channel i SHALL occur in a cycle where in_valid[i] and in_ready[i] are both 1; output transfer SHALL occur where out_valid and out_ready are both 1.
REQ-014 Output register SHALL load when it is empty (out_valid=0) or drained in the same cycle (out_valid=1 and out_ready=1).
REQ-015 in_ready SHALL be the arbiter grant ANDed with the load condition of REQ-014; at most one bit set.
REQ-016 Latency from input transfer to out_valid SHALL be exactly 1 cycle; throughput 1 word per cycle with out_ready held at 1.
REQ-017 While out_valid=1 and out_ready=0, out_data and out_sel SHALL hold stable and all in_ready bits SHALL be 0.
REQ-018 On load, out_data SHALL equal the granted channel's in_data and out_sel its index; out_valid SHALL be 1.
REQ-019 If drained with no request pending, out_valid SHALL fall to 0 the next cycle; out_data keeps its last value.
REQ-020 Fixed-priority mode: grant SHALL go to the lowest-index requesting channel.
REQ-021 Round-robin mode: grant SHALL go to the first requesting channel at or above the pointer, wrapping from N_IN-1 to 0.
REQ-022 The pointer SHALL advance to (granted index + 1) mod N_IN only on an input transfer; unchanged otherwise.
REQ-023 Grant SHALL be purely combinational from in_valid and pointer; a channel dropping in_valid before transfer SHALL lose no state.

Reset
REQ-024 While rst_n=0: out_valid=0, out_data=0, out_sel=0, pointer=0, in_ready=0, asynchronously.
REQ-025 Reset asserted mid-transfer SHALL discard the held word; first accepted word after release SHALL follow REQ-020/021 from pointer 0.

Structure
REQ-026 Shared package SHALL hold the select-width function (max(1,clog2(N))) and the RR_MODE encodings.
REQ-027 Arbitration SHALL be a sub-module rr_arbiter (N_IN, RR_MODE; inputs req, advance; output one-hot grant and index) owning the pointer register.
REQ-028 stream_arb_mux SHALL own only the output register, handshake logic and data selection.

Verification
REQ-029 WIDTH=5, N_IN=4, RR_MODE=1, in_valid=4'b1111 constant, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_valid continuously 1 from cycle 1.
REQ-030 RR_MODE=0, in_valid=4'b1010 constant -> out_sel always 1; channel 3 never granted.
REQ-031 Channel 2 data 5'h15, out_ready=0 for 3 cycles after load -> out_data=5'h15, out_sel=2 stable, in_ready=0 throughout; released when out_ready=1.
REQ-032 Only channel 3 requests with pointer at 3, then only channel 0 -> grants 3 then 0, pointer wraps to 1.
REQ-033 rst_n pulled low while out_valid=1 and out_ready=0 -> out_valid=0 immediately; after release with in_valid=4'b0110, first out_sel=1.
REQ-034 N_IN=2, WIDTH=1 build, alternating requests with random out_ready -> scoreboard shows no loss, duplication or reordering per channel.
